// File: rtl/irq_ctrl_n.sv
// Clocked IE/IF interrupt controller: per-source edge capture, fixed-priority select,
// IDLE/LATCH/VECTOR acknowledge handshake. Optional level-mode sources: IRQ_CTRL_LEVEL_MODE_EN.
module irq_ctrl_n #(
  parameter int          NUM_IRQ   = 8,
  parameter logic [15:0] IE_ADDR   = 16'hFFFF,
  parameter logic [15:0] IF_ADDR   = 16'hFF0F,
  parameter logic [7:0]  VEC_BASE  = 8'h40,
  parameter int          VEC_SHIFT = 3
`ifdef IRQ_CTRL_LEVEL_MODE_EN
  , parameter logic [15:0] MODE_ADDR = 16'hFF0E
`endif
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [15:0]        A,
  input  logic [7:0]         DL_in,
  output logic [7:0]         DL_out,
  input  logic               RD,
  input  logic               WR,
  input  logic [NUM_IRQ-1:0] IRQ_TRIG,
  input  logic               IME,
  input  logic               ACK_REQ,
  output logic               ACK_VALID,
  output logic [7:0]         VEC,
  output logic [NUM_IRQ-1:0] ACK_ONEHOT,
  output logic               IRQ_PENDING,
  output logic               WAKE
);

  typedef enum logic [1:0] {IDLE, LATCH, VECTOR} state_t;

  state_t             state_reg, state_next;
  logic [NUM_IRQ-1:0] trig_q_reg;
  logic [NUM_IRQ-1:0] ie_reg, ie_next;
  logic [NUM_IRQ-1:0] if_reg, if_next;
  logic [NUM_IRQ-1:0] onehot_reg;
  logic [7:0]         vec_reg;

  logic [NUM_IRQ-1:0] rise, set_mask, clr_mask, pend;
  logic               wr_ie, wr_if;
  logic               sel_found;
  logic [2:0]         sel_idx;
  logic [NUM_IRQ-1:0] sel_onehot;
  logic [7:0]         vec_calc;

  assign rise  = IRQ_TRIG & ~trig_q_reg;
  assign wr_ie = WR && (A == IE_ADDR);
  assign wr_if = WR && (A == IF_ADDR);

`ifdef IRQ_CTRL_LEVEL_MODE_EN
  logic [NUM_IRQ-1:0] mode_reg;
  logic               wr_mode;
  assign wr_mode  = WR && (A == MODE_ADDR);
  // Level sources re-assert every cycle the line is high, which also defeats the dispatch clear.
  assign set_mask = (mode_reg & IRQ_TRIG) | (~mode_reg & rise);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) mode_reg <= '0;
    else if (wr_mode) mode_reg <= DL_in[NUM_IRQ-1:0];
  end
`else
  assign set_mask = rise;
`endif

  assign clr_mask = (state_reg == VECTOR) ? onehot_reg : '0;
  assign ie_next  = wr_ie ? DL_in[NUM_IRQ-1:0] : ie_reg;

  // Per bit: a captured edge beats the dispatch clear, which beats a bus write.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_if
    assign if_next[gi] = set_mask[gi] | (~clr_mask[gi] & (wr_if ? DL_in[gi] : if_reg[gi]));
  end

  // Selection uses the post-edge IE/IF so a bus write made during LATCH still counts.
  assign pend = ie_next & if_next;

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = 3'd0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pend[i] && !sel_found) begin
        sel_found     = 1'b1;
        sel_idx       = 3'(i);
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign vec_calc = VEC_BASE + ({5'b0, sel_idx} << VEC_SHIFT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ACK_REQ) state_next = LATCH;
      LATCH:   state_next = VECTOR;
      VECTOR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_reg  <= IDLE;
      trig_q_reg <= '0;
      ie_reg     <= '0;
      if_reg     <= '0;
      onehot_reg <= '0;
      vec_reg    <= 8'h00;
    end else begin
      state_reg  <= state_next;
      trig_q_reg <= IRQ_TRIG;
      ie_reg     <= ie_next;
      if_reg     <= if_next;
      if (state_reg == LATCH) begin
        onehot_reg <= sel_onehot;
        vec_reg    <= sel_found ? vec_calc : 8'h00;
      end
    end
  end

  assign ACK_VALID   = (state_reg == VECTOR);
  assign ACK_ONEHOT  = (state_reg == VECTOR) ? onehot_reg : '0;
  assign VEC         = vec_reg;
  assign WAKE        = |(ie_reg & if_reg);
  assign IRQ_PENDING = WAKE && IME && (state_reg == IDLE);

  always_comb begin
    DL_out = 8'hFF;
    if (RD) begin
      if (A == IE_ADDR)      DL_out[NUM_IRQ-1:0] = ie_reg;
      else if (A == IF_ADDR) DL_out[NUM_IRQ-1:0] = if_reg;
`ifdef IRQ_CTRL_LEVEL_MODE_EN
      else if (A == MODE_ADDR) DL_out[NUM_IRQ-1:0] = mode_reg;
`endif
    end
  end

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Bench for irq_ctrl_n: directed handshake scenarios with literal expectations,
// then randomized traffic compared each cycle against a behavioural model.
module tb_irq_ctrl_n;
  localparam int          N       = 8;
  localparam logic [15:0] IE_A    = 16'hFFFF;
  localparam logic [15:0] IF_A    = 16'hFF0F;
  localparam logic [15:0] MODE_A  = 16'hFF0E;
  localparam int          VBASE   = 8'h40;
  localparam int          VSHIFT  = 3;

  logic         CLK = 1'b0;
  logic         nRESET = 1'b0;
  logic [15:0]  A = 16'h0000;
  logic [7:0]   DL_in = 8'h00;
  logic [7:0]   DL_out;
  logic         RD = 1'b0, WR = 1'b0, IME = 1'b1, ACK_REQ = 1'b0;
  logic [N-1:0] IRQ_TRIG = '0;
  logic         ACK_VALID, IRQ_PENDING, WAKE;
  logic [7:0]   VEC;
  logic [N-1:0] ACK_ONEHOT;

  irq_ctrl_n #(.NUM_IRQ(N), .IE_ADDR(IE_A), .IF_ADDR(IF_A), .VEC_BASE(8'h40), .VEC_SHIFT(VSHIFT)) dut (
    .CLK(CLK), .nRESET(nRESET), .A(A), .DL_in(DL_in), .DL_out(DL_out), .RD(RD), .WR(WR),
    .IRQ_TRIG(IRQ_TRIG), .IME(IME), .ACK_REQ(ACK_REQ), .ACK_VALID(ACK_VALID), .VEC(VEC),
    .ACK_ONEHOT(ACK_ONEHOT), .IRQ_PENDING(IRQ_PENDING), .WAKE(WAKE)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: registers as the programmer sees them plus dispatch phase.
  logic [N-1:0] ie_m = '0, if_m = '0, prev_m = '0, mode_m = '0, oh_m = '0;
  logic [7:0]   vec_m = 8'h00;
  int           phase_m = 0;  // 0 idle, 1 latch, 2 vector

  always @(posedge CLK or negedge nRESET) begin : model
    logic [N-1:0] setm, clr, nif, nie;
    int sel;
    if (!nRESET) begin
      ie_m = '0; if_m = '0; prev_m = '0; mode_m = '0; oh_m = '0; vec_m = 8'h00; phase_m = 0;
    end else begin
      setm = IRQ_TRIG & ~prev_m;
`ifdef IRQ_CTRL_LEVEL_MODE_EN
      setm = setm | (mode_m & IRQ_TRIG);
`endif
      clr = (phase_m == 2) ? oh_m : '0;
      nif = (WR && A == IF_A) ? DL_in[N-1:0] : if_m;
      nie = (WR && A == IE_A) ? DL_in[N-1:0] : ie_m;
      nif = (nif & ~clr) | setm;
`ifdef IRQ_CTRL_LEVEL_MODE_EN
      if (WR && A == MODE_A) mode_m = DL_in[N-1:0];
`endif
      if (phase_m == 1) begin
        sel = -1;
        for (int i = N - 1; i >= 0; i--) if (nie[i] && nif[i]) sel = i;
        oh_m = '0;
        if (sel >= 0) begin
          oh_m[sel] = 1'b1;
          vec_m = 8'((VBASE + sel * (1 << VSHIFT)) & 255);
        end else begin
          vec_m = 8'h00;
        end
      end
      case (phase_m)
        0: phase_m = ACK_REQ ? 1 : 0;
        1: phase_m = 2;
        default: phase_m = 0;
      endcase
      ie_m = nie; if_m = nif; prev_m = IRQ_TRIG;
    end
  end

  function automatic logic [7:0] exp_dl();
    logic [7:0] pad;
    pad = 8'(255 << N);
    if (!RD) return 8'hFF;
    if (A == IE_A) return pad | 8'(ie_m);
    if (A == IF_A) return pad | 8'(if_m);
`ifdef IRQ_CTRL_LEVEL_MODE_EN
    if (A == MODE_A) return pad | 8'(mode_m);
`endif
    return 8'hFF;
  endfunction

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("m_ack_valid", ACK_VALID, phase_m == 2);
      chk("m_ack_onehot", ACK_ONEHOT, (phase_m == 2) ? oh_m : '0);
      chk("m_vec", VEC, vec_m);
      chk("m_wake", WAKE, |(ie_m & if_m));
      chk("m_pending", IRQ_PENDING, (|(ie_m & if_m)) && IME && (phase_m == 0));
      chk("m_dl_out", DL_out, exp_dl());
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
    WR = 1'b0; RD = 1'b0; ACK_REQ = 1'b0;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    A = a; DL_in = d; WR = 1'b1;
    cyc();
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
    A = a; RD = 1'b1;
    settle();
    chk(name, DL_out, exp);
    cyc();
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    cmp_en = 1'b1;
    #1 nRESET = 1'b1;
    settle();
    chk("rst_ack_valid", ACK_VALID, 0);
    chk("rst_vec", VEC, 8'h00);
    chk("rst_onehot", ACK_ONEHOT, 0);
    chk("rst_wake", WAKE, 0);
    chk("rst_pending", IRQ_PENDING, 0);
    chk("rst_idle_bus", DL_out, 8'hFF);
    rd_chk("rst_if", IF_A, 8'h00);

    // Edge on source 2 with IE enabling it.
    bus_wr(IE_A, 8'h04);
    IRQ_TRIG = 8'h04;
    cyc();
    A = IF_A; RD = 1'b1;
    settle();
    chk("edge_if", DL_out, 8'h04);
    chk("edge_wake", WAKE, 1);
    chk("edge_pending", IRQ_PENDING, 1);
    cyc();

    // Dispatch of source 2.
    bus_wr(IE_A, 8'h1F);
    bus_wr(IF_A, 8'h14);
    ACK_REQ = 1'b1;
    cyc();
    settle();
    chk("latch_no_valid", ACK_VALID, 0);
    cyc();
    settle();
    chk("disp_valid", ACK_VALID, 1);
    chk("disp_vec", VEC, 8'h50);
    chk("disp_onehot", ACK_ONEHOT, 8'h04);
    cyc();
    rd_chk("disp_if_after", IF_A, 8'h10);

    // Cancel: IE cleared while in LATCH.
    ACK_REQ = 1'b1;
    cyc();
    A = IE_A; DL_in = 8'h00; WR = 1'b1;
    cyc();
    settle();
    chk("cancel_valid", ACK_VALID, 1);
    chk("cancel_vec", VEC, 8'h00);
    chk("cancel_onehot", ACK_ONEHOT, 0);
    cyc();
    rd_chk("cancel_if", IF_A, 8'h10);

    // Edge beats a same-cycle bus write of 0.
    IRQ_TRIG = 8'h05;
    A = IF_A; DL_in = 8'h00; WR = 1'b1;
    cyc();
    rd_chk("edge_vs_write", IF_A, 8'h01);

    // Edge beats the dispatch clear on the same bit.
    bus_wr(IE_A, 8'h01);
    IRQ_TRIG = 8'h04;
    ACK_REQ = 1'b1;
    cyc();
    cyc();
    IRQ_TRIG = 8'h05;
    settle();
    chk("clr_race_onehot", ACK_ONEHOT, 8'h01);
    cyc();
    rd_chk("edge_vs_clear", IF_A, 8'h01);

    // A held line produces one edge only.
    bus_wr(IF_A, 8'h00);
    repeat (10) cyc();
    rd_chk("held_line", IF_A, 8'h00);
`ifdef IRQ_CTRL_LEVEL_MODE_EN
    bus_wr(MODE_A, 8'h01);
    rd_chk("level_reset", IF_A, 8'h01);
    bus_wr(MODE_A, 8'h00);
`endif

    // Asynchronous reset in the middle of LATCH.
    bus_wr(IF_A, 8'h01);
    ACK_REQ = 1'b1;
    cyc();
    #3 nRESET = 1'b0;
    #1;
    chk("arst_valid", ACK_VALID, 0);
    chk("arst_wake", WAKE, 0);
    chk("arst_vec", VEC, 8'h00);
    chk("arst_onehot", ACK_ONEHOT, 0);
    cyc();
    nRESET = 1'b1;
    IRQ_TRIG = '0;
    rd_chk("arst_ie", IE_A, 8'h00);
    settle();
    chk("arst_no_valid", ACK_VALID, 0);

    // Randomized traffic checked by the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 3))
        0: A = IE_A;
        1: A = IF_A;
        2: A = MODE_A;
        default: A = 16'($urandom);
      endcase
      DL_in    = 8'($urandom);
      WR       = ($urandom_range(0, 3) == 0);
      RD       = 1'($urandom_range(0, 1));
      ACK_REQ  = ($urandom_range(0, 3) == 0);
      IME      = 1'($urandom_range(0, 1));
      IRQ_TRIG = IRQ_TRIG ^ (N'($urandom) & N'($urandom) & N'($urandom));
      @(posedge CLK);
      #1;
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
